// File: rtl/mem_1r1w_stream_reader_if.sv
// ---------------------------------------------------------------------------
// mem_1r1w_stream_reader_if
//
// Bundles the signals of the burst read sequencer: the command handshake,
// the memory read port (R0_*) and the output stream.
//
//   master : the reader side (consumes commands and read data, drives the
//            memory read port and the output stream)
//   slave  : the environment side (command source, memory, consumer)
//
// Signals:
//   cmd_valid / cmd_ready / cmd_addr / cmd_len : burst command handshake
//   R0_addr / R0_en / R0_data                  : memory read port
//   out_valid / out_ready / out_data / out_last: output word stream
//   busy                                       : sequencer is not idle
// ---------------------------------------------------------------------------
interface mem_1r1w_stream_reader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 64,
    parameter int LEN_WIDTH  = 6
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic [ADDR_WIDTH-1:0] R0_addr;
    logic                  R0_en;
    logic [WIDTH-1:0]      R0_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;

    logic                  busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, R0_data, out_ready,
        output cmd_ready, R0_addr, R0_en, out_valid, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, R0_data, out_ready,
        input  cmd_ready, R0_addr, R0_en, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/mem_1r1w_stream_reader.sv
// ---------------------------------------------------------------------------
// mem_1r1w_stream_reader
//
// Read-side sequencer for a simple-dual-port memory with a fixed 1-cycle
// read latency. A burst command (start address, beat count) is turned into
// a run of memory reads; the returned words are buffered in a 2-entry FIFO
// and presented as a valid/ready stream with a last flag. Reads are only
// issued when the word is guaranteed a FIFO slot, so backpressure never
// drops or duplicates a word. Addresses wrap silently modulo DEPTH.
//
// Ports:
//   clock    : single clock (also the memory read clock at the parent)
//   reset_n  : asynchronous active-low reset
//   bus      : mem_1r1w_stream_reader_if.master (command, R0 port, stream)
//   perf_stall (only with `MEM_READER_PERF_EN): saturating 32-bit count of
//              cycles with out_valid=1 and out_ready=0
//
// Optional feature macro: MEM_READER_PERF_EN
// ---------------------------------------------------------------------------
module mem_1r1w_stream_reader #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 64,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                        clock,
    input  logic                        reset_n,
    mem_1r1w_stream_reader_if.master    bus
`ifdef MEM_READER_PERF_EN
    ,
    output logic [31:0]                 perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] r0_addr_hold;
    logic [LEN_WIDTH-1:0]  remaining_q;

    // Read issued in the previous cycle; its data is on R0_data now.
    logic                  rd_vld_p1;
    logic                  rd_last_p1;

    logic [WIDTH-1:0]      fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  cmd_fire;
    logic                  pop;
    logic                  push;
    logic                  r0_en;
    logic [1:0]            occ_next;
    logic [2:0]            pending;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    // Issue decision: a new read is allowed only if the words already
    // buffered (after this cycle's pop) plus the one in flight leave room.
    // out_ready reaches R0_en combinationally so a draining consumer keeps
    // the pipe full at one beat per cycle.
    always_comb begin
        cmd_fire = (state == S_IDLE) && bus.cmd_valid;
        pop      = (count != 2'd0) && bus.out_ready;
        push     = rd_vld_p1;
        occ_next = count - {1'b0, pop};
        pending  = {1'b0, occ_next} + {2'b00, rd_vld_p1};
        r0_en    = (state == S_ISSUE) && (remaining_q != '0) && (pending < 3'd2);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // A zero-length command is accepted but leaves us idle.
                if (cmd_fire && (bus.cmd_len != '0)) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (remaining_q == '0) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((occ_next == 2'd0) && !rd_vld_p1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- stage p0: command latch and read issue ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            r0_addr_hold <= '0;
        end else if (cmd_fire) begin
            addr_q      <= bus.cmd_addr;
            remaining_q <= bus.cmd_len;
        end else if (r0_en) begin
            addr_q       <= next_addr(addr_q);
            remaining_q  <= remaining_q - LEN_WIDTH'(1);
            r0_addr_hold <= addr_q;
        end
    end

    // ---- stage p1: memory read latency, capture into the FIFO ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= r0_en;
            if (r0_en) begin
                rd_last_p1 <= (remaining_q == LEN_WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= bus.R0_data;
                fifo_last[wr_ptr] <= rd_last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // ---- stage p2: stream output from the FIFO head ----
    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.R0_en     = r0_en;
        // Address shows the live issue address, otherwise the last one used.
        bus.R0_addr   = r0_en ? addr_q : r0_addr_hold;
        bus.out_valid = (count != 2'd0);
        bus.out_data  = fifo_data[rd_ptr];
        bus.out_last  = fifo_last[rd_ptr];
        bus.busy      = (state != S_IDLE);
    end

`ifdef MEM_READER_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall <= '0;
        end else if ((count != 2'd0) && !bus.out_ready && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_1r1w_stream_reader.md
# mem_1r1w_stream_reader

Read-side sequencer for the `mem_1r1w` 32x64 simple-dual-port memory. It accepts a burst command (start address, beat count) and drives the memory read port (`R0_addr`, `R0_en`), absorbing the fixed 1-cycle read latency. Returned words are presented as a valid/ready stream with a last flag, and output backpressure never drops or duplicates a word. It sits between the memory wrapper and any consumer that drains buffered data, for example a DMA egress path.

## Interface
- `DEPTH`, 32: memory depth in words; must be a power of two.
- `ADDR_WIDTH`, 5: log2(`DEPTH`).
- `WIDTH`, 64: data width; must match the memory.
- `LEN_WIDTH`, 6: width of the beat count.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock. It also feeds `R0_clk` at the parent level.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_addr` in `ADDR_WIDTH`: first word address.
- `cmd_len` in `LEN_WIDTH`: number of beats, 0..63.
- `R0_addr` out `ADDR_WIDTH`: memory read address.
- `R0_en` out 1: memory read enable.
- `R0_data` in `WIDTH`: memory read data, valid one cycle after `R0_en`.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: consumer ready.
- `out_data` out `WIDTH`: stream word.
- `out_last` out 1: final beat of the burst.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- State machine:
  - IDLE: `cmd_ready`=1. A handshake with `cmd_len`>0 goes to ISSUE and latches `addr`=`cmd_addr` and `remaining`=`cmd_len`. A handshake with `cmd_len`=0 is accepted and stays in IDLE; no read is issued and no beat is output.
  - ISSUE: issue reads until `remaining`=0, then go to DRAIN.
  - DRAIN: wait until nothing is in flight and the buffer is empty, then go to IDLE.
- Issue rule: `R0_en` = (state==ISSUE) && (`remaining`!=0) && (occ_next + inflight < 2).
  - occ_next is the buffer occupancy after this cycle's pop. A pop is `out_valid && out_ready`.
  - inflight is 1 if `R0_en` was high in the previous cycle.
  - The path from `out_ready` to `R0_en` is combinational.
- On each issue: `R0_addr`=`addr`; then `addr` ← (`addr`+1) mod `DEPTH`, so wrap-around is silent; `remaining` decrements.
- One cycle after an issue, `R0_data` is written into a 2-entry FIFO together with its last flag. The last flag is set when that read had `remaining`==1 at issue time.
- `out_data` and `out_last` come from the FIFO head. `out_valid` = FIFO not empty.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold steady.
- Bursts longer than `DEPTH` re-read from the wrapped address. This is legal.
- `cmd_ready` is low during ISSUE and DRAIN. A command offered there waits; it is not dropped.

## Timing
- Reset values:
  - `cmd_ready`=1, `R0_en`=0, `R0_addr`=0.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0, FIFO empty, state IDLE.
- Reset asserted mid-burst aborts the burst immediately. Buffered and in-flight data are discarded. Data returned by the memory after reset is ignored.
- Command handshake in cycle 0:
  - First `R0_en` is in cycle 1 with `R0_addr`=`cmd_addr`.
  - `R0_data` is captured at the end of cycle 2.
  - First `out_valid` is in cycle 3.
- With `out_ready` held high, throughput is one beat per cycle. A burst of N beats produces its last beat in cycle N+2, and the FSM is back in IDLE in cycle N+3.
- `R0_addr` holds its last value while `R0_en`=0.
- At most 2 words are ever buffered or in flight combined.

## Configuration
- `MEM_READER_PERF_EN` defined:
  - Adds output `perf_stall` (32 bits). It counts cycles with `out_valid`=1 and `out_ready`=0.
  - It saturates at 0xFFFFFFFF and resets to 0 on `reset_n`.
- `MEM_READER_PERF_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Preload words 0..31 with value 0x1000+addr. Command addr=4, len=3, `out_ready`=1 → `R0_en` in cycles 1–3 at addresses 4, 5, 6. Outputs 0x1004, 0x1005, 0x1006 in cycles 3–5; `out_last` high only in cycle 5.
- Command addr=30, len=4 → read addresses 30, 31, 0, 1. Data 0x101E, 0x101F, 0x1000, 0x1001.
- Command addr=0, len=8 with `out_ready` toggling 1,0,0,1,… → all 8 words appear in order, none dropped or duplicated. `R0_en` never leaves more than 2 words buffered or in flight. `out_data` stays stable during stalls.
- Command len=0 → `cmd_ready` stays 1, `busy` stays 0, and there is no `R0_en` or `out_valid`. A second command in the next cycle is accepted.
- Pull `reset_n` low in cycle 4 of a len=10 burst → all outputs return to reset values asynchronously. After release, a new len=1 command returns exactly one word with `out_last`=1.
- With `MEM_READER_PERF_EN`: len=2 with `out_ready` low for 5 cycles after the first `out_valid` → `perf_stall`=5.
